// File: rtl/mult_sequencer_pkg.sv
// Shared types for the iterative shift-add multiplier sequencer.
package mult_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

endpackage

// File: rtl/mult_sequencer.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU; holds the execute
// stage through stall until the selected product half is ready.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int EARLY_ZERO = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic             kill,
  input  logic             signed_a,
  input  logic             signed_b,
  input  logic             half,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int ACC_W = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1)
  // which still fits unsigned in WIDTH bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  mult_state_t      state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [ACC_W-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             neg_q,    neg_d;
  logic             half_q,   half_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             a_neg;
  logic             b_neg;
  logic             zero_op;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] acc_final;

  assign a_neg   = signed_a & a[WIDTH-1];
  assign b_neg   = signed_b & b[WIDTH-1];
  assign zero_op = (a == '0) || (b == '0);
  assign addend  = {{WIDTH{1'b0}}, mcand_q} << count_q;

  always_comb begin
    // NOTE: every _d starts from its hold value so no branch can infer a latch.
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    half_d    = half_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    result_d  = result_q;
    acc_final = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          mcand_d  = magnitude(a, signed_a);
          mplier_d = magnitude(b, signed_b);
          neg_d    = a_neg ^ b_neg;
          half_d   = half;
          acc_d    = '0;
          count_d  = '0;
          if ((EARLY_ZERO != 0) && zero_op) begin
            // Product is zero regardless of signs, so skip straight to DONE.
            neg_d    = 1'b0;
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = '0;
          end else begin
            state_d = MULT;
            busy_d  = 1'b1;
          end
        end
      end

      MULT: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + addend;
          end
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CNT_W'(1);
          busy_d   = 1'b1;
          if (count_q == CNT_W'(WIDTH - 1)) begin
            state_d = NEG;
          end
        end
      end

      NEG: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_final;
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = half_q ? acc_final[ACC_W-1:WIDTH] : acc_final[WIDTH-1:0];
        end
      end

      DONE: begin
        // The pipeline owns discarding a killed result, so DONE always completes.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      half_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      half_q   <= half_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign stall  = (start & ~kill & (state_q == IDLE)) | (state_q == MULT) | (state_q == NEG);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: table vectors, random ops against a
// 64-bit arithmetic model, and hand sequences for kill, held start and reset.
module tb_mult_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start, kill, signed_a, signed_b, half;
  logic [31:0] a, b;

  logic        stall_e, busy_e, done_e;
  logic [31:0] result_e;
  logic        stall_n, busy_n, done_n;
  logic [31:0] result_n;

  int n_checks = 0;
  int n_pass   = 0;

  mult_sequencer #(.WIDTH(32), .EARLY_ZERO(1)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .kill(kill),
    .signed_a(signed_a), .signed_b(signed_b), .half(half), .a(a), .b(b),
    .stall(stall_e), .busy(busy_e), .done(done_e), .result(result_e)
  );

  mult_sequencer #(.WIDTH(32), .EARLY_ZERO(0)) dut_nz (
    .CLK(CLK), .nRST(nRST), .start(start), .kill(kill),
    .signed_a(signed_a), .signed_b(signed_b), .half(half), .a(a), .b(b),
    .stall(stall_n), .busy(busy_n), .done(done_n), .result(result_n)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Reference: extend each operand to 64 bits by its signedness and multiply.
  function automatic logic [31:0] ref_mul(input logic [31:0] ra, input logic [31:0] rb,
                                          input logic rsa, input logic rsb, input logic rh);
    longint     xa, xb;
    logic [63:0] p;
    xa = rsa ? longint'($signed(ra)) : longint'({32'b0, ra});
    xb = rsb ? longint'($signed(rb)) : longint'({32'b0, rb});
    p  = 64'(xa * xb);
    return rh ? p[63:32] : p[31:0];
  endfunction

  // Cycle 0 is the cycle in which start is presented; done is expected in
  // cycle exp_lat on the EARLY_ZERO=1 instance and cycle 34 on the other.
  task automatic do_mult(input logic [31:0] ta, input logic [31:0] tb, input logic tsa,
                         input logic tsb, input logic th, input logic [31:0] exp_res,
                         input int exp_lat, input string name);
    int          lat_e, lat_n, pulses_e, pulses_n, stall_cnt;
    logic        stall_at_done;
    logic [31:0] res_e, res_n;
    lat_e = -1; lat_n = -1; pulses_e = 0; pulses_n = 0; stall_cnt = 0;
    stall_at_done = 1'b1; res_e = '0; res_n = '0;
    @(posedge CLK); #1;
    a = ta; b = tb; signed_a = tsa; signed_b = tsb; half = th; start = 1'b1; kill = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) begin
        @(posedge CLK); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        signed_a = 1'($urandom); signed_b = 1'($urandom); half = 1'($urandom);
      end
      #1;
      if (done_e) begin
        pulses_e++;
        if (lat_e < 0) begin lat_e = c; res_e = result_e; stall_at_done = stall_e; end
      end else if (lat_e < 0 && stall_e) begin
        stall_cnt++;
      end
      if (done_n) begin
        pulses_n++;
        if (lat_n < 0) begin lat_n = c; res_n = result_n; end
      end
    end
    check({name, "_result"},     64'(res_e),         64'(exp_res));
    check({name, "_latency"},    64'(lat_e),         64'(exp_lat));
    check({name, "_pulses"},     64'(pulses_e),      64'd1);
    check({name, "_stall_cyc"},  64'(stall_cnt),     64'(exp_lat));
    check({name, "_stall_done"}, 64'(stall_at_done), 64'd0);
    check({name, "_nz_result"},  64'(res_n),         64'(exp_res));
    check({name, "_nz_latency"}, 64'(lat_n),         64'd34);
    check({name, "_nz_pulses"},  64'(pulses_n),      64'd1);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        sa, sb, h;
    logic [31:0] exp_res;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          done_cycles[$];
    logic [31:0] done_results[$];
    int          pulses;

    vecs[0] = '{32'd7,        32'd6,        1'b1, 1'b1, 1'b0, 32'h0000002A, 34, "mul_7x6"};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 34, "mulhu_max"};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h00000000, 34, "mulh_m1"};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000, 34, "mulh_minneg"};
    vecs[4] = '{32'hFFFFFFFF, 32'd2,        1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 34, "mulhsu_m1x2"};
    vecs[5] = '{32'd0,        32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00000000, 1,  "mul_zero_a"};
    vecs[6] = '{32'd5,        32'd0,        1'b1, 1'b1, 1'b1, 32'h00000000, 1,  "mulh_zero_b"};
    vecs[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h80000000, 34, "mulhsu_minneg"};
    vecs[8] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 34, "mul_minneg_lo"};

    nRST = 1'b0; start = 1'b0; kill = 1'b0; signed_a = 1'b0; signed_b = 1'b0;
    half = 1'b0; a = '0; b = '0;
    #12;
    check("reset_busy",   64'(busy_e),   64'd0);
    check("reset_done",   64'(done_e),   64'd0);
    check("reset_result", 64'(result_e), 64'd0);
    check("reset_stall",  64'(stall_e),  64'd0);
    #1 nRST = 1'b1;

    foreach (vecs[i])
      do_mult(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, vecs[i].h,
              vecs[i].exp_res, vecs[i].lat, vecs[i].name);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      logic        rsa, rsb, rh;
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = '0;
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFFFFFF;
      rsa = 1'($urandom); rsb = 1'($urandom); rh = 1'($urandom);
      do_mult(ra, rb, rsa, rsb, rh, ref_mul(ra, rb, rsa, rsb, rh),
              ((ra == 0) || (rb == 0)) ? 1 : 34, $sformatf("rand%0d", i));
    end

    // Kill mid-iteration: no done pulse, stall and busy drop after the kill edge.
    @(posedge CLK); #1;
    a = 32'd3; b = 32'd5; signed_a = 1'b0; signed_b = 1'b0; half = 1'b0;
    start = 1'b1; kill = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      kill  = (c == 10);
      #1;
      if (c == 10) check("kill_busy_before", 64'(busy_e), 64'd1);
      if (c == 11) begin
        check("kill_stall_after",   64'(stall_e), 64'd0);
        check("kill_busy_after",    64'(busy_e),  64'd0);
        check("kill_nz_busy_after", 64'(busy_n),  64'd0);
      end
      if (done_e || done_n) pulses++;
    end
    check("kill_no_done", 64'(pulses), 64'd0);

    // Start held through DONE: no restart in DONE, re-accept in the next IDLE.
    @(posedge CLK); #1;
    a = 32'd9; b = 32'd9; signed_a = 1'b0; signed_b = 1'b0; half = 1'b0;
    start = 1'b1; kill = 1'b0;
    for (int c = 0; c <= 75; c++) begin
      if (c > 0) begin
        @(posedge CLK); #1;
        if (c == 36) start = 1'b0;
      end
      #1;
      if (done_e) begin done_cycles.push_back(c); done_results.push_back(result_e); end
      if (c == 34) check("hold_stall_in_done",   64'(stall_e), 64'd0);
      if (c == 35) begin
        check("hold_reaccept_stall", 64'(stall_e), 64'd1);
        check("hold_no_done_repeat", 64'(done_e),  64'd0);
      end
      if (c == 36) check("hold_reaccept_busy",   64'(busy_e),  64'd1);
    end
    check("hold_pulses", 64'(done_cycles.size()), 64'd2);
    if (done_cycles.size() >= 1) begin
      check("hold_first_cycle",  64'(done_cycles[0]),  64'd34);
      check("hold_first_result", 64'(done_results[0]), 64'h51);
    end
    if (done_cycles.size() >= 2) begin
      check("hold_second_cycle",  64'(done_cycles[1]),  64'd69);
      check("hold_second_result", 64'(done_results[1]), 64'h51);
    end

    // Asynchronous reset mid-MULT clears outputs immediately.
    @(posedge CLK); #1;
    a = 32'h1234; b = 32'h5678; signed_a = 1'b0; signed_b = 1'b0; half = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge CLK); #1;
      start = 1'b0;
    end
    #1;
    check("arst_busy_before",   64'(busy_e),   64'd1);
    check("arst_result_before", 64'(result_e), 64'h51);
    #1 nRST = 1'b0;
    #1;
    check("arst_busy",   64'(busy_e),   64'd0);
    check("arst_done",   64'(done_e),   64'd0);
    check("arst_result", 64'(result_e), 64'd0);
    @(posedge CLK); #3;
    nRST = 1'b1;
    do_mult(32'd2, 32'd3, 1'b1, 1'b1, 1'b0, 32'd6, 34, "post_reset_2x3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
